// File: rtl/carousel_pkg.sv
// Shared definitions for the carousel lane rotator and its receive-side de-rotator.
package carousel_pkg;

    typedef enum logic [1:0] {
        CAR_COLLECT  = 2'd0,
        CAR_ROTATE   = 2'd1,
        CAR_DISPENSE = 2'd2
    } carousel_rx_state_t;

    // Index of the lane that feeds lane i when the group is rotated back one step.
    function automatic int rot_prev(input int i, input int n);
        return (i + n - 1) % n;
    endfunction

endpackage

// File: rtl/carousel_lane_slot.sv
// One lane of the de-rotator: a data register plus a flag saying the lane holds a word.
// clear (drain) beats load (collect) beats rotate; the top only ever raises one of them.
module carousel_lane_slot
    import carousel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rotate,
    input  logic [WIDTH-1:0] rotate_data,
    input  logic             clear,
    output logic [WIDTH-1:0] data_q,
    output logic             held_q
);

    logic [WIDTH-1:0] data_d;
    logic             held_d;

    // Next-state selection for the lane word and its held flag.
    always_comb begin
        data_d = data_q;
        held_d = held_q;
        if (clear) begin
            held_d = 1'b0;
        end else if (load) begin
            data_d = load_data;
            held_d = 1'b1;
        end else if (rotate) begin
            data_d = rotate_data;
        end
    end

    // Lane register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            held_q <= 1'b0;
        end else begin
            data_q <= data_d;
            held_q <= held_d;
        end
    end

endmodule

// File: rtl/carousel_derotate.sv
// Receive-side carousel de-rotator: collects one word per lane plus the upstream shift
// count, rotates the group back one step per cycle, then drains each lane independently.
module carousel_derotate
    import carousel_pkg::*;
#(
    parameter  int NUM_LANES = 3,
    parameter  int WIDTH     = 8,
    localparam int SHIFT_W   = $clog2(NUM_LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES*WIDTH-1:0] data_in,
    input  logic [NUM_LANES-1:0]       data_in_valid,
    output logic [NUM_LANES-1:0]       data_in_ready,
    input  logic [SHIFT_W-1:0]         shift_in,
    input  logic                       shift_in_valid,
    output logic                       shift_in_ready,
    output logic [NUM_LANES*WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]       data_out_valid,
    input  logic [NUM_LANES-1:0]       data_out_ready,
    output logic                       busy
);

    carousel_rx_state_t state_q, state_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
    logic               shift_held_q, shift_held_d;

    logic [WIDTH-1:0]     lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] held;
    logic [NUM_LANES-1:0] lane_load;
    logic [NUM_LANES-1:0] lane_clear;
    logic                 lane_rotate;

    logic [NUM_LANES-1:0] in_xfer;
    logic [NUM_LANES-1:0] out_xfer;
    logic                 shift_xfer;
    logic                 group_done;
    logic                 drain_done;
    logic [SHIFT_W-1:0]   eff_cnt;

    assign in_xfer    = data_in_valid & data_in_ready;
    assign shift_xfer = shift_in_valid & shift_in_ready;
    assign out_xfer   = data_out_valid & data_out_ready;

    // A group is complete once every lane and the shift count are held or arriving now.
    assign group_done = (&(held | in_xfer)) && (shift_held_q || shift_xfer);
    assign eff_cnt    = shift_xfer ? shift_in : cnt_q;
    assign drain_done = ((held & ~out_xfer) == '0);

    // Lane slots; each rotate pulls from the previous lane so lane i takes lane i-1.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        carousel_lane_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .load        (lane_load[i]),
            .load_data   (data_in[i*WIDTH +: WIDTH]),
            .rotate      (lane_rotate),
            .rotate_data (lane_data[rot_prev(i, NUM_LANES)]),
            .clear       (lane_clear[i]),
            .data_q      (lane_data[i]),
            .held_q      (held[i])
        );
    end

    // Ready/valid/data decode from registered state only.
    always_comb begin
        data_in_ready  = '0;
        shift_in_ready = 1'b0;
        data_out_valid = '0;
        data_out       = '0;
        busy           = (state_q != CAR_COLLECT);
        case (state_q)
            CAR_COLLECT: begin
                data_in_ready  = ~held;
                shift_in_ready = ~shift_held_q;
            end
            CAR_DISPENSE: begin
                data_out_valid = held;
                for (int i = 0; i < NUM_LANES; i++) begin
                    data_out[i*WIDTH +: WIDTH] = lane_data[i];
                end
            end
            default: begin
            end
        endcase
    end

    // Next-state logic for the FSM, rotate counter, shift flag and lane controls.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_held_d = shift_held_q;
        lane_load    = '0;
        lane_clear   = '0;
        lane_rotate  = 1'b0;
        case (state_q)
            CAR_COLLECT: begin
                lane_load = in_xfer;
                if (shift_xfer) begin
                    cnt_d        = shift_in;
                    shift_held_d = 1'b1;
                end
                if (group_done) begin
                    state_d = (eff_cnt == '0) ? CAR_DISPENSE : CAR_ROTATE;
                end
            end
            CAR_ROTATE: begin
                lane_rotate = 1'b1;
                cnt_d       = cnt_q - SHIFT_W'(1);
                if (cnt_q == SHIFT_W'(1)) begin
                    state_d = CAR_DISPENSE;
                end
            end
            CAR_DISPENSE: begin
                lane_clear = out_xfer;
                if (drain_done) begin
                    shift_held_d = 1'b0;
                    state_d      = CAR_COLLECT;
                end
            end
            default: begin
                state_d = CAR_COLLECT;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CAR_COLLECT;
            cnt_q        <= '0;
            shift_held_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_held_q <= shift_held_d;
        end
    end

endmodule

// File: tb/tb_carousel_derotate.sv
// Scoreboard bench for carousel_derotate: stimulus pushes the expected de-rotated group,
// a monitor pops and compares each lane as it transfers out.
module tb_carousel_derotate;

    localparam int N       = 3;
    localparam int W       = 8;
    localparam int NW      = N * W;
    localparam int SHIFT_W = $clog2(N);

    logic              clk;
    logic              rst;
    logic [NW-1:0]     data_in;
    logic [N-1:0]      data_in_valid;
    logic [N-1:0]      data_in_ready;
    logic [SHIFT_W-1:0] shift_in;
    logic              shift_in_valid;
    logic              shift_in_ready;
    logic [NW-1:0]     data_out;
    logic [N-1:0]      data_out_valid;
    logic [N-1:0]      data_out_ready;
    logic              busy;

    int errors = 0;
    int checks = 0;

    logic [NW-1:0] exp_q [$];
    logic [N-1:0]  drained = '0;
    logic [NW-1:0] mon_front;

    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: manual
    logic [N-1:0]  manual_rdy = '0;
    logic [N-1:0]  rand_rdy;

    carousel_derotate #(
        .NUM_LANES (N),
        .WIDTH     (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .shift_in       (shift_in),
        .shift_in_valid (shift_in_valid),
        .shift_in_ready (shift_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_out_ready = (rdy_mode == 2) ? manual_rdy : rand_rdy;

    always @(posedge clk) begin
        #1;
        rand_rdy = (rdy_mode == 0) ? {N{1'b1}} : N'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: after k backward steps, output lane j carries input lane (j - k) mod N.
    function automatic logic [NW-1:0] derot(input logic [NW-1:0] d, input int k);
        logic [NW-1:0] r;
        for (int j = 0; j < N; j++) begin
            r[j*W +: W] = d[((j - (k % N) + N) % N)*W +: W];
        end
        return r;
    endfunction

    // Upstream carousel: lane i takes lane i+1.
    function automatic logic [NW-1:0] fwd(input logic [NW-1:0] d);
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i*W +: W] = d[((i + 1) % N)*W +: W];
        end
        return r;
    endfunction

    // Monitor: compare every output lane transfer against the front expected group.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                if (data_out_valid[i] && data_out_ready[i]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out lane %0d: got %0h expected no output", i, data_out[i*W +: W]);
                    end else begin
                        mon_front = exp_q[0];
                        check($sformatf("out_lane%0d", i), 32'(data_out[i*W +: W]), 32'(mon_front[i*W +: W]));
                        drained[i] = 1'b1;
                    end
                end
            end
            if (exp_q.size() != 0 && (&drained)) begin
                void'(exp_q.pop_front());
                drained = '0;
            end
        end
    end

    task automatic send_group(input logic [NW-1:0] d, input int k, input logic [NW-1:0] exp,
                              input int maxdly, input string tag);
        int dly [N];
        int sdly;
        logic [N-1:0] got;
        logic sgot;
        int cyc;
        int n;
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, maxdly);
        sdly = $urandom_range(0, maxdly);
        exp_q.push_back(exp);
        got  = '0;
        sgot = 1'b0;
        cyc  = 0;
        while (!((&got) && sgot) && cyc < 100) begin
            for (int i = 0; i < N; i++) begin
                data_in_valid[i] = !got[i] && (cyc >= dly[i]);
                data_in[i*W +: W] = data_in_valid[i] ? d[i*W +: W] : W'($urandom);
            end
            shift_in_valid = !sgot && (cyc >= sdly);
            shift_in = shift_in_valid ? SHIFT_W'(k) : SHIFT_W'($urandom);
            @(negedge clk);
            got = got | (data_in_valid & data_in_ready);
            if (shift_in_valid && shift_in_ready) sgot = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        data_in_valid  = '0;
        shift_in_valid = 1'b0;
        check({tag, "_accept"}, 32'((&got) && sgot), 32'd1);
        n = 0;
        while (data_out_valid == '0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(k));
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        check({tag, "_idle_ready"}, {28'd0, data_in_ready, shift_in_ready}, {28'd0, {N{1'b1}}, 1'b1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NW-1:0] d;
        int k;

        rst            = 1'b0;
        data_in        = '0;
        data_in_valid  = '0;
        shift_in       = '0;
        shift_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",    32'(data_in_ready),  32'(3'b111));
        check("rst_shift_ready", 32'(shift_in_ready), 32'd1);
        check("rst_out_valid",   32'(data_out_valid), 32'd0);
        check("rst_busy",        32'(busy),           32'd0);
        check("rst_data_out",    32'(data_out),       32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        send_group(24'h332211, 0, 24'h332211, 0, "shift0");
        send_group(24'h332211, 1, 24'h221133, 0, "shift1");
        send_group(24'h332211, 2, 24'h113322, 0, "shift2");
        send_group(fwd(24'h332211), 1, 24'h332211, 0, "roundtrip");
        send_group(24'h332211, 3, 24'h332211, 2, "shift3");

        // Staggered arrival and per-lane drain, shift 1.
        rdy_mode   = 2;
        manual_rdy = '0;
        exp_q.push_back(24'h554466);
        for (int t = 0; t <= 14; t++) begin
            data_in        = 24'h665544;
            data_in_valid  = {t == 0, t == 5, t == 5};
            shift_in       = SHIFT_W'(1);
            shift_in_valid = (t == 3);
            manual_rdy     = {t == 12, t == 10, t == 8};
            @(negedge clk);
            if (t >= 6 && t <= 12) begin
                check($sformatf("stag_in_ready_t%0d", t), 32'(data_in_ready), 32'd0);
                check($sformatf("stag_shift_ready_t%0d", t), 32'(shift_in_ready), 32'd0);
            end
            if (t == 13) begin
                check("stag_in_ready_t13", 32'(data_in_ready), 32'(3'b111));
                check("stag_shift_ready_t13", 32'(shift_in_ready), 32'd1);
            end
            if (t == 6)  check("stag_valid_t6",  32'(data_out_valid), 32'(3'b000));
            if (t == 7)  check("stag_valid_t7",  32'(data_out_valid), 32'(3'b111));
            if (t == 9)  check("stag_valid_t9",  32'(data_out_valid), 32'(3'b110));
            if (t == 11) check("stag_valid_t11", 32'(data_out_valid), 32'(3'b100));
            if (t == 13) check("stag_valid_t13", 32'(data_out_valid), 32'(3'b000));
            @(posedge clk);
            #1;
        end
        data_in_valid  = '0;
        shift_in_valid = 1'b0;
        manual_rdy     = '0;
        rdy_mode       = 0;

        // Reset asserted during the first rotate cycle of a shift-2 group.
        data_in        = 24'h998877;
        data_in_valid  = '1;
        shift_in       = SHIFT_W'(2);
        shift_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid  = '0;
        shift_in_valid = 1'b0;
        check("rotate_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_in_ready",    32'(data_in_ready),  32'(3'b111));
        check("midrst_shift_ready", 32'(shift_in_ready), 32'd1);
        check("midrst_out_valid",   32'(data_out_valid), 32'd0);
        check("midrst_busy",        32'(busy),           32'd0);
        check("midrst_data_out",    32'(data_out),       32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_group(24'h030201, 0, 24'h030201, 2, "post_rst");

        // Randomized groups with random arrival and random output back-pressure.
        rdy_mode = 1;
        for (int g = 0; g < 40; g++) begin
            d = NW'($urandom);
            k = $urandom_range(0, 3);
            send_group(d, k, derot(d, k), 4, $sformatf("rand%0d", g));
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
